alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter RR_INIT, default 0, which is the round-robin pointer value after reset (0 means requester 1 wins the first tie).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_op  input  4  requester 0 ALU operation code.
REQ-007 req0_a, req0_b  input  8 each  requester 0 operands A and B.
REQ-008 req1_valid, req1_ready, req1_op, req1_a, req1_b  same directions and widths as REQ-004..007, for requester 1.
REQ-009 rsp_valid  output  1  response holds a completed result.
REQ-010 rsp_ready  input  1  consumer accepts the response.
REQ-011 rsp_id  output  1  index of the requester that owns the response.
REQ-012 rsp_result  output  8  operation result.
REQ-013 rsp_zero  output  1  high when rsp_result == 0.
REQ-014 rsp_illegal  output  1  high when the op code was not a defined code.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-017 IDLE: if at least one valid is high, grant one requester, assert only that requester's ready (combinationally, same cycle), capture its op/a/b and the grant id into internal registers, and go to EXEC; if no valid is high, stay in IDLE with both readys low.
REQ-018 Arbitration: if only one valid is high, that requester wins; if both are high, the requester not equal to the pointer wins.
REQ-019 The pointer SHALL be set to the granted id at the grant cycle; a lone requester therefore cannot be starved while the other waits.
REQ-020 The readys SHALL be low in EXEC and RESP, and requester inputs SHALL be ignored outside the grant cycle.
REQ-021 EXEC: compute on the captured operands and register result, zero and illegal in one cycle, then go to RESP.
REQ-022 Op codes, with all arithmetic modulo 2^8 and carry/borrow discarded: 0001 A+B; 0010 A-B; 0011 A&B; 0100 A|B; 0101 A^B; 0110 ~A; 0111 A<<1 with LSB 0; 1000 A>>1 logical with MSB 0; 1111 B.
REQ-023 Any other op code SHALL give result 0x00, zero 1 and illegal 1.
REQ-024 RESP: assert rsp_valid and hold rsp_id, rsp_result, rsp_zero and rsp_illegal stable until the cycle in which rsp_ready is high; then go to IDLE.
REQ-025 A new grant SHALL NOT occur in the same cycle as the response handshake.
REQ-026 Timing: grant at cycle N gives rsp_valid first high at N+2; with rsp_ready held high, the next grant comes no earlier than N+3.
REQ-027 rsp_ready asserted in IDLE or EXEC SHALL have no effect.
REQ-028 Response payload outputs SHALL be registered and SHALL NOT change while rsp_valid is high.

Reset
REQ-029 On a clock edge with rst high: state to IDLE; pointer to RR_INIT; rsp_valid, rsp_id, rsp_result, rsp_illegal and busy to 0; rsp_zero to 1; both readys low.
REQ-030 Reset mid-operation (EXEC or RESP) SHALL discard the in-flight operation with no response produced.
REQ-031 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-032 Single request: req0 op 0001, A=0x7F, B=0x01, rsp_ready=1 -> req0_ready high at N; at N+2 rsp_valid=1, rsp_id=0, rsp_result=0x80, rsp_zero=0.
REQ-033 Wrap and zero: req1 op 0010, A=0x05, B=0x05 -> rsp_result=0x00, rsp_zero=1, rsp_id=1; op 0001 with A=0xFF, B=0x01 -> 0x00, zero=1.
REQ-034 Contention: both valids held high with different ops, after reset with RR_INIT=0 -> grants in the order 1,0,1,0; each response's rsp_id and result match that requester's operands.
REQ-035 Backpressure: rsp_ready held low for 5 cycles in RESP -> rsp_valid and payload stable, both readys low, busy=1; rsp_ready high -> IDLE on the next cycle.
REQ-036 Illegal and shifts: op 1001 -> result 0x00, zero=1, illegal=1; op 0111 with A=0x81 -> 0x02; op 1000 with A=0x81 -> 0x40; op 0110 with A=0xFF -> 0x00, zero=1.
REQ-037 Reset mid-operation: rst pulsed high for one cycle in EXEC -> no rsp_valid afterwards, busy=0, and the pointer restored to RR_INIT, checked by the next tie grant.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters, the arbiter and the response consumer.
interface alu_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_op;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_op;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_result;
  logic       rsp_zero;
  logic       rsp_illegal;
  logic       busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single-cycle 8-bit ALU.
//   state | meaning
//   IDLE  | waiting for a request; grant and capture happen here
//   EXEC  | ALU evaluates captured operands, result registered
//   RESP  | response presented until rsp_ready
module alu_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  state_t     state_nxt;

  logic       ptr;
  logic       req_any;
  logic       gnt_id;
  logic       grant;

  logic       id_q;
  logic [3:0] op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;

  logic [7:0] alu_res;
  logic       alu_ill;

  logic       rsp_id_q;
  logic [7:0] rsp_result_q;
  logic       rsp_zero_q;
  logic       rsp_illegal_q;

  logic       ready0;
  logic       ready1;

  // On a tie the requester other than the last winner is granted.
  always_comb begin
    req_any = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_id = ~ptr;
    end else begin
      gnt_id = bus.req1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset masks the combinational readys so nothing is accepted on a reset edge.
  always_comb begin
    grant  = 1'b0;
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (state == IDLE && req_any && !rst) begin
      grant  = 1'b1;
      ready0 = ~gnt_id;
      ready1 = gnt_id;
    end
  end

  always_comb begin
    alu_res = 8'h00;
    alu_ill = 1'b0;
    case (op_q)
      4'h1:    alu_res = a_q + b_q;
      4'h2:    alu_res = a_q - b_q;
      4'h3:    alu_res = a_q & b_q;
      4'h4:    alu_res = a_q | b_q;
      4'h5:    alu_res = a_q ^ b_q;
      4'h6:    alu_res = ~a_q;
      4'h7:    alu_res = {a_q[6:0], 1'b0};
      4'h8:    alu_res = {1'b0, a_q[7:1]};
      4'hF:    alu_res = b_q;
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= RR_INIT;
      id_q          <= 1'b0;
      op_q          <= 4'h0;
      a_q           <= 8'h00;
      b_q           <= 8'h00;
      rsp_id_q      <= 1'b0;
      rsp_result_q  <= 8'h00;
      rsp_zero_q    <= 1'b1;
      rsp_illegal_q <= 1'b0;
    end else begin
      if (grant) begin
        ptr  <= gnt_id;
        id_q <= gnt_id;
        op_q <= gnt_id ? bus.req1_op : bus.req0_op;
        a_q  <= gnt_id ? bus.req1_a  : bus.req0_a;
        b_q  <= gnt_id ? bus.req1_b  : bus.req0_b;
      end
      // Payload only moves in EXEC, so it is frozen for the whole of RESP.
      if (state == EXEC) begin
        rsp_id_q      <= id_q;
        rsp_result_q  <= alu_res;
        rsp_zero_q    <= (alu_res == 8'h00);
        rsp_illegal_q <= alu_ill;
      end
    end
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.rsp_valid   = (state == RESP);
  assign bus.busy        = (state != IDLE);
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_alu_arbiter;

  localparam logic RR_INIT = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_arbiter_if bus();

  alu_arbiter #(.RR_INIT(RR_INIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Returns {illegal, zero, result[7:0]} from the opcode table using integer arithmetic.
  function automatic logic [9:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia = int'(a);
    int ib = int'(b);
    int r  = 0;
    bit ill = 1'b0;
    case (op)
      4'h1: r = (ia + ib) % 256;
      4'h2: r = (ia - ib + 256) % 256;
      4'h3: r = ia & ib;
      4'h4: r = ia | ib;
      4'h5: r = ia ^ ib;
      4'h6: r = 255 - ia;
      4'h7: r = (ia * 2) % 256;
      4'h8: r = ia / 2;
      4'hF: r = ib;
      default: begin r = 0; ill = 1'b1; end
    endcase
    return {ill, (r == 0), 8'(r)};
  endfunction

  typedef struct {
    logic       id;
    logic [9:0] val;
  } exp_t;

  exp_t q[$];
  bit   pending   = 1'b0;
  bit   after_rst = 1'b0;
  logic m_ptr     = RR_INIT;
  int   cyc       = 0;
  int   gcyc      = 0;

  // Transaction-level scoreboard: one op in flight, response due two cycles after the grant.
  always @(negedge clk) begin
    bit   exp_valid;
    bit   g0;
    bit   g1;
    exp_t e;
    cyc++;
    if (rst) begin
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      pending   = 1'b0;
      m_ptr     = RR_INIT;
      after_rst = 1'b1;
      q.delete();
    end else begin
      if (after_rst) begin
        chk("rst_result", bus.rsp_result, 0);
        chk("rst_zero", bus.rsp_zero, 1);
        chk("rst_id", bus.rsp_id, 0);
        chk("rst_illegal", bus.rsp_illegal, 0);
        after_rst = 1'b0;
      end
      exp_valid = pending && (cyc - gcyc >= 2);
      chk("busy", bus.busy, pending);
      chk("rsp_valid", bus.rsp_valid, exp_valid);
      if (!pending) begin
        g0 = bus.req0_valid && (!bus.req1_valid || m_ptr == 1'b1);
        g1 = bus.req1_valid && (!bus.req0_valid || m_ptr == 1'b0);
        chk("ready0", bus.req0_ready, g0);
        chk("ready1", bus.req1_ready, g1);
        if (g0 || g1) begin
          e.id  = g1;
          e.val = g1 ? alu_ref(bus.req1_op, bus.req1_a, bus.req1_b)
                     : alu_ref(bus.req0_op, bus.req0_a, bus.req0_b);
          q.push_back(e);
          m_ptr   = g1;
          pending = 1'b1;
          gcyc    = cyc;
        end
      end else begin
        chk("ready0_busy", bus.req0_ready, 0);
        chk("ready1_busy", bus.req1_ready, 0);
        if (exp_valid) begin
          chk("sb_id", bus.rsp_id, q[0].id);
          chk("sb_result", bus.rsp_result, q[0].val[7:0]);
          chk("sb_zero", bus.rsp_zero, q[0].val[8]);
          chk("sb_illegal", bus.rsp_illegal, q[0].val[9]);
          if (bus.rsp_ready) begin
            void'(q.pop_front());
            pending = 1'b0;
          end
        end
      end
    end
  end

  task automatic set_req(input int r, input logic v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic wait_gnt(output logic id);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(bus.req0_ready || bus.req1_ready) && n < 20);
    chk("gnt_timeout", (n < 20), 1);
    id = bus.req1_ready;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.rsp_valid && lat < 20);
    chk("rsp_timeout", (lat < 20), 1);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Issues one op from requester r with rsp_ready high; returns the response seen at N+2.
  task automatic do_op(input int r, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] res, output logic zero, output logic ill, output logic id);
    logic gid;
    int   lat;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    set_req(r, 1'b1, op, a, b);
    wait_gnt(gid);
    chk("op_gnt_id", gid, r);
    @(posedge clk); #1;
    set_req(r, 1'b0, 4'h0, 8'h00, 8'h00);
    wait_rsp(lat);
    chk("op_latency", lat, 2);
    res  = bus.rsp_result;
    zero = bus.rsp_zero;
    ill  = bus.rsp_illegal;
    id   = bus.rsp_id;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] res;
    logic       zero;
    logic       ill;
    logic       id;
    logic [7:0] held;
    int         lat;

    set_req(0, 1'b0, 4'h0, 8'h00, 8'h00);
    set_req(1, 1'b0, 4'h0, 8'h00, 8'h00);
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);

    // single request with explicit cycle-by-cycle view
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, 4'h1, 8'h7F, 8'h01);
    @(negedge clk);
    chk("single_ready0", bus.req0_ready, 1);
    chk("single_ready1", bus.req1_ready, 0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 4'h0, 8'h00, 8'h00);
    @(negedge clk);
    chk("single_n1_valid", bus.rsp_valid, 0);
    @(negedge clk);
    chk("single_n2_valid", bus.rsp_valid, 1);
    chk("single_id", bus.rsp_id, 0);
    chk("single_result", bus.rsp_result, 8'h80);
    chk("single_zero", bus.rsp_zero, 0);

    // wrap-around and zero flag
    do_op(1, 4'h2, 8'h05, 8'h05, res, zero, ill, id);
    chk("sub_result", res, 8'h00); chk("sub_zero", zero, 1); chk("sub_id", id, 1);
    do_op(0, 4'h1, 8'hFF, 8'h01, res, zero, ill, id);
    chk("add_wrap_result", res, 8'h00); chk("add_wrap_zero", zero, 1);

    // illegal code and shifts
    do_op(0, 4'h9, 8'h12, 8'h34, res, zero, ill, id);
    chk("illegal_result", res, 8'h00); chk("illegal_zero", zero, 1); chk("illegal_flag", ill, 1);
    do_op(1, 4'h7, 8'h81, 8'h00, res, zero, ill, id);
    chk("shl_result", res, 8'h02); chk("shl_illegal", ill, 0);
    do_op(0, 4'h8, 8'h81, 8'h00, res, zero, ill, id);
    chk("shr_result", res, 8'h40);
    do_op(1, 4'h6, 8'hFF, 8'h00, res, zero, ill, id);
    chk("not_result", res, 8'h00); chk("not_zero", zero, 1);

    // contention after reset: both held high, grants must alternate starting with requester 1
    apply_reset();
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, 4'h1, 8'h10, 8'h22);
    set_req(1, 1'b1, 4'h5, 8'hF0, 8'h3C);
    for (int k = 0; k < 4; k++) begin
      logic gid;
      wait_gnt(gid);
      chk("tie_order", gid, (k % 2 == 0) ? 1 : 0);
      wait_rsp(lat);
      chk("tie_rsp_id", bus.rsp_id, gid);
      chk("tie_result", bus.rsp_result, gid ? 8'hCC : 8'h32);
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 4'h0, 8'h00, 8'h00);
    set_req(1, 1'b0, 4'h0, 8'h00, 8'h00);

    // backpressure in RESP
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 4'h3, 8'hF0, 8'h3C);
    wait_gnt(id);
    @(posedge clk); #1;
    set_req(0, 1'b0, 4'h0, 8'h00, 8'h00);
    set_req(1, 1'b1, 4'hF, 8'h00, 8'h5A);
    wait_rsp(lat);
    chk("bp_result", bus.rsp_result, 8'h30);
    held = bus.rsp_result;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_stable", bus.rsp_result, held);
      chk("bp_ready1", bus.req1_ready, 0);
      chk("bp_busy", bus.busy, 1);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("hs_no_grant", bus.req1_ready, 0);
    @(negedge clk);
    chk("hs_idle_busy", bus.busy, 0);
    chk("hs_next_grant", bus.req1_ready, 1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 4'h0, 8'h00, 8'h00);
    repeat (4) @(posedge clk);

    // reset while in EXEC, after a requester-1 grant moved the pointer
    #1;
    set_req(1, 1'b1, 4'h1, 8'h01, 8'h02);
    wait_gnt(id);
    chk("abort_gnt", id, 1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 4'h0, 8'h00, 8'h00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_rsp", bus.rsp_valid, 0);
      chk("abort_busy", bus.busy, 0);
    end
    @(posedge clk); #1;
    set_req(0, 1'b1, 4'h1, 8'h01, 8'h01);
    set_req(1, 1'b1, 4'h1, 8'h02, 8'h02);
    @(negedge clk);
    chk("abort_ptr_tie1", bus.req1_ready, 1);
    chk("abort_ptr_tie0", bus.req0_ready, 0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 4'h0, 8'h00, 8'h00);
    set_req(1, 1'b0, 4'h0, 8'h00, 8'h00);
    repeat (4) @(posedge clk);

    // random traffic with occasional resets
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      rst           = ($urandom_range(0, 99) == 0);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      set_req(0, ($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      set_req(1, ($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b0, 4'h0, 8'h00, 8'h00);
    set_req(1, 1'b0, 4'h0, 8'h00, 8'h00);
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
